// File: rtl/fm_mix_dac.sv
// FM output stage: frame-rate snapshot of three voices, mute, sum, shift-add volume scaling,
// saturation to a 12-bit DAC word and a first-order sigma-delta bitstream.
module fm_mix_dac #(
    parameter int SAMPLE_DIV = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sample_1,
    input  logic [11:0] sample_2,
    input  logic [11:0] sample_3,
    input  logic [2:0]  mute,
    input  logic [3:0]  master_vol,
    output logic [13:0] mix_word,
    output logic [11:0] dac_word,
    output logic        mix_valid,
    output logic        clip,
    output logic        dac_out
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    // The frame pipeline needs six cycles plus the idle slot before the next snapshot.
    generate
        if (SAMPLE_DIV < 8) begin : g_bad_div
            $error("fm_mix_dac: SAMPLE_DIV must be >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        MUL  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_e0;
    logic [11:0]       r_s1;
    logic [11:0]       r_s2;
    logic [11:0]       r_s3;
    logic [2:0]        r_mute;
    logic [3:0]        r_vol;
    logic [13:0]       w_masked;
    logic [13:0]       r_sum;
    logic [17:0]       r_prod;
    logic [1:0]        r_bit;
    logic [12:0]       w_prodHi;
    logic [13:0]       r_mix;
    logic [11:0]       r_dac;
    logic              r_clip;
    logic              r_valid;
    logic [11:0]       r_sdAcc;
    logic [12:0]       w_sdSum;
    logic              r_dacOut;

    assign w_e0 = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_e0) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_mute <= '0;
            r_vol  <= '0;
        end else if (w_e0) begin
            r_s1   <= sample_1;
            r_s2   <= sample_2;
            r_s3   <= sample_3;
            r_mute <= mute;
            r_vol  <= master_vol;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_e0) w_next = SUM;
            SUM:     w_next = MUL;
            MUL:     if (r_bit == 2'd0) w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_masked = (r_mute[0] ? 14'd0 : {2'b00, r_s1})
                    + (r_mute[1] ? 14'd0 : {2'b00, r_s2})
                    + (r_mute[2] ? 14'd0 : {2'b00, r_s3});

    assign w_prodHi = r_prod[17:5];

    // Volume bits are consumed MSB first so the product builds by shift-and-add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= '0;
            r_prod  <= '0;
            r_bit   <= '0;
            r_mix   <= '0;
            r_dac   <= '0;
            r_clip  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                SUM: begin
                    r_sum  <= w_masked;
                    r_prod <= '0;
                    r_bit  <= 2'd3;
                end
                MUL: begin
                    r_prod <= {r_prod[16:0], 1'b0} + (r_vol[r_bit] ? {4'b0000, r_sum} : 18'd0);
                    r_bit  <= r_bit - 2'd1;
                end
                OUT: begin
                    r_mix   <= r_prod[17:4];
                    r_dac   <= (w_prodHi > 13'd4095) ? 12'hFFF : r_prod[16:5];
                    r_clip  <= (w_prodHi > 13'd4095);
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_sdSum = {1'b0, r_sdAcc} + {1'b0, r_dac};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sdAcc  <= '0;
            r_dacOut <= 1'b0;
        end else begin
            r_sdAcc  <= w_sdSum[11:0];
            r_dacOut <= w_sdSum[12];
        end
    end

    assign mix_word  = r_mix;
    assign dac_word  = r_dac;
    assign clip      = r_clip;
    assign mix_valid = r_valid;
    assign dac_out   = r_dacOut;

endmodule

// File: tb/tb_fm_mix_dac.sv
// Self-checking bench for fm_mix_dac: table of frames checked against an arithmetic model,
// plus hand sequences for mid-frame input changes, mid-frame reset and sigma-delta density.
module tb_fm_mix_dac;

    localparam int SAMPLE_DIV = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] sample_1 = '0;
    logic [11:0] sample_2 = '0;
    logic [11:0] sample_3 = '0;
    logic [2:0]  mute = '0;
    logic [3:0]  master_vol = '0;
    logic [13:0] mix_word;
    logic [11:0] dac_word;
    logic        mix_valid;
    logic        clip;
    logic        dac_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] s1;
        logic [11:0] s2;
        logic [11:0] s3;
        logic [2:0]  mute;
        logic [3:0]  vol;
        int          expMix;
        int          expDac;
        int          expClip;
    } vec_t;

    fm_mix_dac #(.SAMPLE_DIV(SAMPLE_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_1   (sample_1),
        .sample_2   (sample_2),
        .sample_3   (sample_3),
        .mute       (mute),
        .master_vol (master_vol),
        .mix_word   (mix_word),
        .dac_word   (dac_word),
        .mix_valid  (mix_valid),
        .clip       (clip),
        .dac_out    (dac_out)
    );

    always #5 clk = ~clk;

    // Reference: gain is vol/16 on the muted sum, DAC word is half the mix, clamped to 12 bits.
    function automatic vec_t makeVec(input int s1, input int s2, input int s3,
                                     input int m, input int vol);
        vec_t v;
        int   sum;
        int   half;
        sum = 0;
        if ((m & 1) == 0) sum += s1;
        if ((m & 2) == 0) sum += s2;
        if ((m & 4) == 0) sum += s3;
        v.s1     = 12'(s1);
        v.s2     = 12'(s2);
        v.s3     = 12'(s3);
        v.mute   = 3'(m);
        v.vol    = 4'(vol);
        v.expMix = (sum * vol) / 16;
        half     = v.expMix / 2;
        v.expDac = (half > 4095) ? 4095 : half;
        v.expClip = (half > 4095) ? 1 : 0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        sample_1   = v.s1;
        sample_2   = v.s2;
        sample_3   = v.s3;
        mute       = v.mute;
        master_vol = v.vol;
    endtask

    task automatic waitValid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * SAMPLE_DIV; i++) begin
            tick();
            if (mix_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL valid_timeout: actual=no pulse required=pulse within %0d cycles",
                     2 * SAMPLE_DIV);
        end
    endtask

    // Expects reset to have just been released; the first pulse must come SAMPLE_DIV+6 edges later.
    task automatic measureFirstValid(input string tag);
        int k;
        k = -1;
        for (int i = 1; i <= SAMPLE_DIV + 20; i++) begin
            tick();
            if (mix_valid === 1'b1) begin
                k = i;
                break;
            end
        end
        checkOutput({tag, "_valid_latency"}, k, SAMPLE_DIV + 6);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_mix"}, mix_word, 0);
        checkOutput({tag, "_dac"}, dac_word, 0);
        checkOutput({tag, "_valid"}, mix_valid, 0);
        checkOutput({tag, "_clip"}, clip, 0);
        checkOutput({tag, "_dacout"}, dac_out, 0);
    endtask

    // Called right after the mix_valid edge; leaves the bench one edge later.
    task automatic checkFrame(input string tag, input vec_t v);
        checkOutput({tag, "_mix"}, mix_word, v.expMix);
        checkOutput({tag, "_dac"}, dac_word, v.expDac);
        checkOutput({tag, "_clip"}, clip, v.expClip);
        tick();
        checkOutput({tag, "_valid_low"}, mix_valid, 0);
        checkOutput({tag, "_clip_hold"}, clip, v.expClip);
    endtask

    task automatic sdTest(input string tag, input vec_t v, input bit checkPeriod4);
        bit ok;
        int ones;
        int breaks;
        bit hist[4096];
        waitValid(ok);
        applyStimulus(v);
        waitValid(ok);
        checkFrame(tag, v);
        ones = 0;
        breaks = 0;
        for (int n = 0; n < 4096; n++) begin
            if (n > 0) tick();
            hist[n] = dac_out;
            if (dac_out === 1'b1) ones++;
            if (n >= 4 && hist[n] != hist[n-4]) breaks++;
        end
        checkOutput({tag, "_ones"}, ones, v.expDac);
        if (checkPeriod4) checkOutput({tag, "_period4_breaks"}, breaks, 0);
        checkOutput({tag, "_dac_steady"}, dac_word, v.expDac);
    endtask

    initial begin
        vec_t vecs[13];
        vec_t vb;
        vec_t vc;
        vec_t vd;
        bit   ok;
        time  prevT;

        vecs[0] = '{12'd1000, 12'd1000, 12'd1000, 3'b000, 4'd15, 2812, 1406, 0};
        vecs[1] = '{12'd4095, 12'd4095, 12'd4095, 3'b000, 4'd15, 11517, 4095, 1};
        vecs[2] = '{12'd0, 12'd0, 12'd0, 3'b000, 4'd15, 0, 0, 0};
        vecs[3] = '{12'd2000, 12'd4095, 12'd4095, 3'b110, 4'd8, 1000, 500, 0};
        vecs[4] = '{12'd2000, 12'd4095, 12'd4095, 3'b110, 4'd0, 0, 0, 0};
        vecs[5] = '{12'd4095, 12'd4095, 12'd548, 3'b000, 4'd15, 8191, 4095, 0};
        vecs[6] = '{12'd4095, 12'd4095, 12'd549, 3'b000, 4'd15, 8192, 4095, 1};
        for (int i = 7; i < 13; i++) begin
            vecs[i] = makeVec($urandom_range(0, 4095), $urandom_range(0, 4095),
                              $urandom_range(0, 4095), $urandom_range(0, 7),
                              $urandom_range(0, 15));
        end

        // Power-on reset, asserted between clock edges.
        #2 rst = 1'b1;
        #1 checkResetOutputs("por");
        applyStimulus(vecs[0]);
        @(negedge clk) rst = 1'b0;
        measureFirstValid("por");
        prevT = $time;
        checkFrame("vec0", vecs[0]);

        for (int i = 1; i < 13; i++) begin
            applyStimulus(vecs[i]);
            waitValid(ok);
            if (ok) begin
                checkOutput($sformatf("vec%0d_period", i), int'(($time - prevT) / 10), SAMPLE_DIV);
                prevT = $time;
                checkFrame($sformatf("vec%0d", i), vecs[i]);
            end
        end

        // Inputs changed two cycles after the snapshot must not affect the frame in flight.
        vb = makeVec(1234, 567, 3000, 3'b010, 11);
        vc = makeVec(4000, 4000, 4000, 3'b000, 2);
        vd = makeVec(300, 2500, 1700, 3'b001, 13);
        applyStimulus(vb);
        repeat (SAMPLE_DIV - 7) tick();
        repeat (2) tick();
        applyStimulus(vc);
        repeat (3) tick();
        checkOutput("midchg_valid_e5", mix_valid, 0);
        tick();
        checkOutput("midchg_valid_e6", mix_valid, 1);
        checkFrame("midchg", vb);

        // Reset during the multiply: frame abandoned, next frame after release uses new inputs.
        repeat (SAMPLE_DIV - 7) tick();
        repeat (2) tick();
        applyStimulus(vd);
        tick();
        #2 rst = 1'b1;
        #1 checkResetOutputs("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        measureFirstValid("midrst");
        checkFrame("midrst", vd);

        sdTest("sd1024", makeVec(4095, 1, 0, 0, 8), 1'b1);
        sdTest("sd4095", makeVec(4095, 4095, 4095, 0, 15), 1'b0);
        sdTest("sd0", makeVec(4095, 4095, 4095, 0, 0), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
